// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    Idle,
    StartBit,
    DataBits,
    StopBit,
    WaitRxHigh,
    WaitForGoLow
  } uart_rx_state_e;

  function automatic int bit_time(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 1 (idle line level).
module uart_rx_sync #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with go/dr handshake; registers update on the falling clock edge.
// Optional UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote over the last three samples of each bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int ClockFrequencyHz = 66_000_000,
  parameter int BaudRate         = 9600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      go,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      dr
);

  localparam int BIT_TIME = bit_time(ClockFrequencyHz, BaudRate);
  localparam int CNT_W    = $clog2(BIT_TIME);
  localparam int BCNT_W   = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0]  HALF_LOAD = CNT_W'(BIT_TIME / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_LOAD = CNT_W'(BIT_TIME - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(UART_DATA_BITS - 1);

  generate
    if (BIT_TIME < 4) begin : g_bit_time_check
      $error("uart_rx_frame: BIT_TIME must be at least 4");
    end
  endgenerate

  logic rx_s;

  uart_rx_sync #(.DATA_W(1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  logic bit_sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  // The window is the two previous rx_s samples plus the current one, so the
  // decision at counter 0 covers counter values 2, 1 and 0.
  logic [1:0] vote_hist;
  logic [2:0] vote_window;

  always_ff @(negedge clk) begin
    if (!rst_n) vote_hist <= 2'b11;
    else        vote_hist <= {vote_hist[0], rx_s};
  end

  assign vote_window = {vote_hist, rx_s};
  assign bit_sample  = majority3(vote_window);
`else
  assign bit_sample = rx_s;
`endif

  uart_rx_state_e              state;
  logic [CNT_W-1:0]            cnt;
  logic [BCNT_W-1:0]           bit_cnt;
  logic [UART_DATA_BITS-1:0]   shift;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state   <= Idle;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data    <= '0;
      dr      <= 1'b0;
    end else begin
      case (state)
        Idle: begin
          if (go && !rx_s) begin
            cnt   <= HALF_LOAD;
            state <= StartBit;
          end
        end
        StartBit: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!bit_sample) begin
            cnt     <= FULL_LOAD;
            bit_cnt <= '0;
            state   <= DataBits;
          end else begin
            state <= Idle;
          end
        end
        DataBits: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shift   <= {bit_sample, shift[UART_DATA_BITS-1:1]};
            cnt     <= FULL_LOAD;
            bit_cnt <= bit_cnt + BCNT_W'(1);
            if (bit_cnt == LAST_BIT) state <= StopBit;
          end
        end
        StopBit: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (bit_sample) begin
            data  <= shift;
            dr    <= 1'b1;
            state <= WaitForGoLow;
          end else begin
            state <= WaitRxHigh;
          end
        end
        // A held break must return high before a new start edge is accepted.
        WaitRxHigh: begin
          if (rx_s) state <= Idle;
        end
        WaitForGoLow: begin
          if (!go) begin
            dr    <= 1'b0;
            state <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: time-based receiver model plus directed and random frames.
module tb_uart_rx_frame;

  localparam int FREQ = 20;
  localparam int BAUD = 2;
  localparam int BT   = 10;
  localparam int H    = BT / 2;
  localparam int HMAX = 16383;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       go = 1'b0;
  logic [7:0] data;
  logic       dr;

  uart_rx_frame #(.ClockFrequencyHz(FREQ), .BaudRate(BAUD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .go   (go),
    .data (data),
    .dr   (dr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int ncyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", name, ncyc, act, exp);
  endtask

  // Reference model: rx line history indexed by falling-edge number, with
  // decisions taken at fixed offsets from the start-detect edge t0.
  logic       rxh [0:HMAX];
  int         m_mode = 0;   // 0 idle, 1 in frame, 2 wait line high, 3 wait go low
  int         m_t0 = 0;
  logic [7:0] m_shift = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic       m_dr = 1'b0;

  function automatic logic rxs(input int n);
    if (n < 2) return 1'b1;
    return rxh[n-2];
  endfunction

  function automatic logic samp(input int n);
`ifdef UART_RX_MAJORITY_VOTE_EN
    int ones;
    ones = int'(rxs(n-2)) + int'(rxs(n-1)) + int'(rxs(n));
    return (ones >= 2);
`else
    return rxs(n);
`endif
  endfunction

  always @(negedge clk) begin
    int n, k;
    ncyc = ncyc + 1;
    n = ncyc;
    if (n <= HMAX) rxh[n] = rx;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) if (n - i >= 0 && n - i <= HMAX) rxh[n-i] = 1'b1;
      m_mode = 0;
      m_data = 8'h00;
      m_dr   = 1'b0;
    end else begin
      case (m_mode)
        0: if (go && !rxs(n)) begin
             m_mode = 1;
             m_t0   = n;
           end
        1: begin
             k = n - m_t0;
             if (k == H) begin
               if (samp(n)) m_mode = 0;
             end else if (k > H && k < H + 9 * BT && (k - H) % BT == 0) begin
               m_shift = {samp(n), m_shift[7:1]};
             end else if (k == H + 9 * BT) begin
               if (samp(n)) begin
                 m_data = m_shift;
                 m_dr   = 1'b1;
                 m_mode = 3;
               end else begin
                 m_mode = 2;
               end
             end
           end
        2: if (rxs(n)) m_mode = 0;
        default: if (!go) begin
             m_dr   = 1'b0;
             m_mode = 0;
           end
      endcase
    end
  end

  logic dr_prev = 1'b0;
  int   dr_rise = -1;

  always @(posedge clk) begin
    if (chk_en) begin
      check("dr_cycle", dr, m_dr);
      check("data_cycle", data, m_data);
    end
    if (dr === 1'b1 && dr_prev !== 1'b1) dr_rise = ncyc;
    dr_prev = dr;
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      rx = 1'b1;
    end
  endtask

  // Drives a 100-cycle 8N1 frame; glitch_at inverts one cycle, cut_at stops early.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_at,
                            input int cut_at, output int e);
    int   len;
    int   bi;
    logic val;
    e   = -1;
    len = (cut_at >= 0) ? cut_at : 10 * BT;
    for (int c = 0; c < len; c++) begin
      bi = c / BT;
      if (bi == 0)      val = 1'b0;
      else if (bi == 9) val = stop;
      else              val = b[bi-1];
      if (c == glitch_at) val = ~val;
      @(posedge clk);
      rx = val;
      if (c == 0) e = ncyc + 1;
    end
  endtask

  task automatic pulse_go_low(input int k);
    @(posedge clk);
    go = 1'b0;
    repeat (k) @(posedge clk);
    go = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [7:0] rb;
    for (int i = 0; i <= HMAX; i++) rxh[i] = 1'b1;

    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    check("reset_dr", dr, 1'b0);
    check("reset_data", data, 8'h00);
    rst_n = 1'b1;
    go = 1'b1;
    idle(5);

    // Receive 0xA5 and observe the handshake
    send_frame(8'hA5, 1'b1, -1, -1, e);
    idle(10);
    check("t1_data", data, 8'hA5);
    check("t1_dr_held", dr, 1'b1);
    check("t1_rise_edge", dr_rise, e + 2 + H + 9 * BT);
    @(posedge clk);
    go = 1'b0;
    @(posedge clk);
    check("t1_dr_cleared", dr, 1'b0);
    go = 1'b1;
    idle(3);

    // Short low glitch on idle line, then a good frame
    send_frame(8'h00, 1'b1, -1, 3, e);
    idle(10);
    check("t2_no_dr", dr, 1'b0);
    check("t2_data_kept", data, 8'hA5);
    send_frame(8'h3C, 1'b1, -1, -1, e);
    idle(5);
    check("t2_data", data, 8'h3C);
    pulse_go_low(2);
    idle(3);

    // Framing error followed by a held break
    send_frame(8'h5A, 1'b0, -1, -1, e);
    repeat (30) begin
      @(posedge clk);
      rx = 1'b0;
    end
    idle(5);
    check("t3_no_dr", dr, 1'b0);
    check("t3_data_kept", data, 8'h3C);
    send_frame(8'h81, 1'b1, -1, -1, e);
    idle(5);
    check("t3_data", data, 8'h81);
    pulse_go_low(2);
    idle(3);

    // Back-to-back frames while dr is unacknowledged
    send_frame(8'h11, 1'b1, -1, -1, e);
    send_frame(8'h22, 1'b1, -1, -1, e);
    idle(5);
    check("t4_data", data, 8'h11);
    check("t4_dr", dr, 1'b1);
    pulse_go_low(2);
    idle(3);

    // Reset in the middle of bit 4
    send_frame(8'hC3, 1'b1, -1, 55, e);
    @(posedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    rst_n = 1'b1;
    check("t5_dr", dr, 1'b0);
    check("t5_data", data, 8'h00);
    idle(20);
    send_frame(8'hFF, 1'b1, -1, -1, e);
    idle(5);
    check("t5_data_ff", data, 8'hFF);
    pulse_go_low(2);
    idle(3);

    // One-cycle high pulse at the bit-0 decision point of 0x00
    send_frame(8'h00, 1'b1, 15, -1, e);
    idle(5);
`ifdef UART_RX_MAJORITY_VOTE_EN
    check("t6_data", data, 8'h00);
`else
    check("t6_data", data, 8'h01);
`endif
    pulse_go_low(2);
    idle(3);

    // Random frames, errors, glitches and go activity
    for (int it = 0; it < 30; it++) begin
      rb = 8'($urandom);
      send_frame(rb, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0) ?
                 int'($urandom_range(0, 99)) : -1, -1, e);
      repeat ($urandom_range(1, 12)) begin
        @(posedge clk);
        rx = 1'b1;
        if ($urandom_range(0, 3) == 0) go = ~go;
      end
      if ($urandom_range(0, 1) == 0) go = 1'b1;
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
